// File: rtl/sample_fifo_pkg.sv
// Shared radar FPGA constants: default FIFO geometry and drop-counter helpers.
package sample_fifo_pkg;

    localparam int unsigned FIFO_DWIDTH = 16;
    localparam int unsigned FIFO_AWIDTH = 9;
    localparam int unsigned DROP_CNT_W  = 16;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with occupancy flags, synchronous flush and overflow drop counter.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH      = FIFO_DWIDTH,
    parameter int unsigned AWIDTH      = FIFO_AWIDTH,
    parameter int unsigned AFULL_LEVEL = (2 ** AWIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [AWIDTH:0]       level,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned PW = AWIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_LEVEL);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_seen_q, rd_seen_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_we;
    logic                  ram_re;
    logic [DWIDTH-1:0]     ram_rd_data;

    // Next-state for pointers, level, drop counter and flags; clear overrides both strobes.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_d     = drop_q;
        rd_valid_d = 1'b0;
        rd_seen_d  = rd_seen_q;
        wr_acc     = wr_en && !full_q;
        rd_acc     = rd_en && !empty_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = '0;
        end else begin
            ram_we = wr_acc;
            ram_re = rd_acc;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                rd_valid_d = 1'b1;
                rd_seen_d  = 1'b1;
            end
            if (wr_en && full_q) begin
                drop_d = sat_inc(drop_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
        end

        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d == {~rd_ptr_d[PW-1], rd_ptr_d[PW-2:0]});
        afull_d = (level_d >= AFULL_LVL);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            rd_seen_q  <= rd_seen_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
        end
    end

    fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[AWIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q[AWIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset, so present zero until a read has happened since reset.
    assign rd_data     = rd_seen_q ? ram_rd_data : '0;
    assign rd_valid    = rd_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign level       = level_q;
    assign drop_count  = drop_q;

endmodule
